iomem_uart_master: RTL and testbench
====================================

# iomem_uart_master

Bus-initiator bridge that turns a byte-stream command protocol (fed from the SoC UART receiver) into single PicoSoC iomem read/write transactions, and returns status/read data as a byte stream to the UART transmitter. It drives the initiator side of the iomem bus (valid/addr/wdata/wstrb out, ready/rdata in) so that board debug tools can poke the GPIO, tone and other iomem-mapped peripherals without CPU involvement. It sits beside the picosoc core and feeds an iomem arbiter or multiplexer.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles iomem_valid is held waiting for iomem_ready; 0 disables the timeout.
- clk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- rx_data  in  8  command byte from the UART receiver.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  byte accepted on a cycle where rx_valid && rx_ready.
- tx_data  out  8  response byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid; held with tx_data stable until accepted.
- tx_ready  in  1  transmitter accepts the byte on a cycle where tx_valid && tx_ready.
- iomem_valid  out  1  transaction request.
- iomem_ready  in  1  single-cycle completion from the responder.
- iomem_wstrb  out  4  byte write strobes; 0000 = read.
- iomem_addr  out  32  transaction address.
- iomem_wdata  out  32  write data.
- iomem_rdata  in  32  read data, valid in the iomem_ready cycle.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Command frames (multi-byte fields MSB first):
  - Write: 0x57, addr[4], strb[1] (bits 3:0 used, 7:4 ignored), data[4].
  - Read: 0x52, addr[4].
  - Any other first byte: discarded; response 0x3F.
- Responses:
  - Write OK: 0x06.
  - Read OK: 0x06, then rdata[4] MSB first.
  - Timeout: 0x15 only.
- States:
  - IDLE: waits for an opcode.
  - ADDR: collects 4 bytes.
  - STRB: collects 1 byte (write only).
  - DATA: collects 4 bytes (write only).
  - BUS: drives the transaction.
  - RESP: emits the response bytes.
- Transitions:
  - IDLE -> ADDR on 0x57 or 0x52.
  - IDLE -> RESP on an unknown opcode.
  - ADDR -> STRB (write) or BUS (read) after the 4th byte.
  - STRB -> DATA.
  - DATA -> BUS after the 4th byte.
  - BUS -> RESP on iomem_ready or timeout.
  - RESP -> IDLE after the last byte is accepted.
- Byte index is a 2-bit counter, cleared on every state entry. Address and data are assembled by shifting left by 8 per byte.
- A read drives iomem_wstrb = 0000. A write with strb = 0 still issues a bus cycle with wstrb 0000, i.e. a read whose data is discarded; the response is 0x06 only.
- rx_ready = 1 in IDLE, ADDR, STRB and DATA; 0 in BUS and RESP; 0 while resetn is low.
- No inter-byte timeout; a partial frame waits indefinitely.

## Timing
- Reset values:
  - iomem_valid 0, iomem_addr 0, iomem_wdata 0, iomem_wstrb 0.
  - tx_valid 0, tx_data 0, busy 0.
  - State IDLE, timeout counter 0.
- iomem_valid rises on the cycle after the final command byte is accepted. addr, wdata and wstrb are stable from that cycle until valid falls.
- Bus handshake: valid is held until iomem_ready is sampled high; valid falls on the next cycle. The responder's ready pulse is never seen twice for one request. Zero-wait responders (ready in the first valid cycle) are supported.
- iomem_rdata is captured on the edge where iomem_ready = 1.
- Timeout counter counts cycles with valid high and ready low.
  - When the count reaches TIMEOUT_CYCLES, valid drops on the next cycle and the response is 0x15.
  - If ready arrives in the same cycle the count reaches the limit, ready wins and the response is OK.
- The first response byte has tx_valid high on the cycle after bus completion or timeout, and one cycle after an unknown opcode is accepted.
- Each following byte is presented the cycle after the previous one is accepted; no bubbles under constant tx_ready.
- Under tx_ready = 0, tx_data and tx_valid are held indefinitely.
- Asynchronous reset at any point forces IDLE and the reset values immediately, dropping iomem_valid mid-transaction and any partially sent response.

## Test plan
- Write: 57 03 00 00 00 01 00 00 00 07 with a responder that has 1 wait cycle.
  - Required: one valid pulse of 2 cycles, addr 0x03000000, wstrb 0001, wdata 0x00000007.
  - Response 06.
- Read: 52 06 00 00 00 with rdata 0xDEADBEEF in the ready cycle.
  - Required: wstrb 0000.
  - Response 06 DE AD BE EF.
  - rx_ready is 0 from the last address byte until EF is accepted.
- Timeout: read 52 04 00 00 00, iomem_ready tied low, TIMEOUT_CYCLES = 8.
  - Required: valid high exactly 8 cycles.
  - Response 15.
  - Ready asserted exactly on cycle 8 instead gives 06 plus data.
- Unknown opcode 0xAA followed immediately by a valid write frame.
  - Response 3F, then the write executes normally with response 06.
- Backpressure: read with tx_ready toggled 0/1 every 3 cycles.
  - All 5 bytes arrive in order.
  - tx_data never changes while tx_valid = 1 and tx_ready = 0.
- Reset mid-transaction: assert resetn = 0 while iomem_valid = 1, then release.
  - iomem_valid and busy go 0 without waiting for a clock edge.
  - Next frame 52 05 00 00 00 is accepted from the beginning.

Source files
------------

// File: rtl/iomem_uart_master_if.sv
// Bundles the UART byte-stream handshakes and the iomem initiator bus.
//   master modport: the bridge (consumes rx, produces tx, drives iomem requests)
//   slave modport : the environment (UART rx/tx and the iomem responder)
//   rx_data/rx_valid/rx_ready   command byte stream into the bridge
//   tx_data/tx_valid/tx_ready   response byte stream out of the bridge
//   iomem_valid/addr/wdata/wstrb/ready/rdata   single-transfer iomem bus
interface iomem_uart_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, iomem_ready, iomem_rdata,
        output rx_ready, tx_data, tx_valid, iomem_valid, iomem_wstrb,
               iomem_addr, iomem_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, iomem_ready, iomem_rdata,
        input  rx_ready, tx_data, tx_valid, iomem_valid, iomem_wstrb,
               iomem_addr, iomem_wdata
    );
endinterface

// File: rtl/iomem_uart_master.sv
// UART-command to iomem bridge: parses write (0x57) / read (0x52) frames from
// the rx byte stream, issues one iomem transfer, returns status/read data on tx.
//   clk     system clock (rising edge)
//   resetn  asynchronous active-low reset
//   bus     iomem_uart_master_if.master (rx stream, tx stream, iomem initiator)
//   busy    high whenever the command FSM is not idle
module iomem_uart_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    iomem_uart_master_if.master        bus,
    output logic                       busy
);

    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 2);
    localparam int unsigned RESP_W = 40;
    localparam logic [7:0]  OP_WRITE = 8'h57;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [7:0]  RSP_ACK  = 8'h06;
    localparam logic [7:0]  RSP_NAK  = 8'h15;
    localparam logic [7:0]  RSP_UNK  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STRB, S_DATA, S_BUS, S_RESP
    } state_t;

    state_t              state, state_n;
    logic [1:0]          idx, idx_n;
    logic                is_write, is_write_n;
    logic [31:0]         addr, addr_n;
    logic [31:0]         wdata, wdata_n;
    logic [3:0]          wstrb, wstrb_n;
    logic                valid, valid_n;
    logic [TO_W-1:0]     tocnt, tocnt_n;
    logic [RESP_W-1:0]   resp_buf, resp_buf_n;
    logic [2:0]          resp_len, resp_len_n;
    logic                tx_valid, tx_valid_n;
    logic                busy_n;
    logic                rx_ready_c;
    logic                rx_fire_c;

    // Command bytes are only taken while collecting a frame and never in reset.
    always_comb begin
        rx_ready_c = resetn && (state == S_IDLE || state == S_ADDR ||
                                state == S_STRB || state == S_DATA);
        rx_fire_c  = bus.rx_valid && rx_ready_c;
    end

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            is_write <= 1'b0;
            addr     <= 32'd0;
            wdata    <= 32'd0;
            wstrb    <= 4'd0;
            valid    <= 1'b0;
            tocnt    <= TO_W'(0);
            resp_buf <= RESP_W'(0);
            resp_len <= 3'd0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            is_write <= is_write_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            wstrb    <= wstrb_n;
            valid    <= valid_n;
            tocnt    <= tocnt_n;
            resp_buf <= resp_buf_n;
            resp_len <= resp_len_n;
            tx_valid <= tx_valid_n;
            busy     <= busy_n;
        end
    end

    // Next-state, frame assembly, bus completion and response sequencing.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        is_write_n = is_write;
        addr_n     = addr;
        wdata_n    = wdata;
        wstrb_n    = wstrb;
        tocnt_n    = tocnt;
        resp_buf_n = resp_buf;
        resp_len_n = resp_len;

        case (state)
            S_IDLE: begin
                if (rx_fire_c) begin
                    idx_n = 2'd0;
                    if (bus.rx_data == OP_WRITE) begin
                        is_write_n = 1'b1;
                        state_n    = S_ADDR;
                    end else if (bus.rx_data == OP_READ) begin
                        is_write_n = 1'b0;
                        wstrb_n    = 4'd0;
                        state_n    = S_ADDR;
                    end else begin
                        resp_buf_n = {RSP_UNK, 32'd0};
                        resp_len_n = 3'd1;
                        state_n    = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire_c) begin
                    addr_n = {addr[23:0], bus.rx_data};
                    idx_n  = idx + 2'd1;
                    if (idx == 2'd3) begin
                        idx_n   = 2'd0;
                        tocnt_n = TO_W'(0);
                        state_n = is_write ? S_STRB : S_BUS;
                    end
                end
            end
            S_STRB: begin
                if (rx_fire_c) begin
                    wstrb_n = bus.rx_data[3:0];
                    idx_n   = 2'd0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_fire_c) begin
                    wdata_n = {wdata[23:0], bus.rx_data};
                    idx_n   = idx + 2'd1;
                    if (idx == 2'd3) begin
                        idx_n   = 2'd0;
                        tocnt_n = TO_W'(0);
                        state_n = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // ready takes priority over a timeout landing on the same cycle
                if (bus.iomem_ready) begin
                    if (is_write) begin
                        resp_buf_n = {RSP_ACK, 32'd0};
                        resp_len_n = 3'd1;
                    end else begin
                        resp_buf_n = {RSP_ACK, bus.iomem_rdata};
                        resp_len_n = 3'd5;
                    end
                    idx_n   = 2'd0;
                    state_n = S_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tocnt_n = tocnt + TO_W'(1);
                    if (32'(tocnt) + 32'd1 == TIMEOUT_CYCLES) begin
                        resp_buf_n = {RSP_NAK, 32'd0};
                        resp_len_n = 3'd1;
                        idx_n      = 2'd0;
                        state_n    = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (tx_valid && bus.tx_ready) begin
                    resp_buf_n = {resp_buf[RESP_W-9:0], 8'h00};
                    resp_len_n = resp_len - 3'd1;
                    if (resp_len == 3'd1) begin
                        idx_n   = 2'd0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        valid_n    = (state_n == S_BUS);
        tx_valid_n = (state_n == S_RESP);
        busy_n     = (state_n != S_IDLE);
    end

    assign bus.rx_ready    = rx_ready_c;
    assign bus.tx_data     = resp_buf[RESP_W-1 -: 8];
    assign bus.tx_valid    = tx_valid;
    assign bus.iomem_valid = valid;
    assign bus.iomem_addr  = addr;
    assign bus.iomem_wdata = wdata;
    assign bus.iomem_wstrb = wstrb;

endmodule

// File: tb/tb_iomem_uart_master.sv
// Randomized self-checking bench for iomem_uart_master (TIMEOUT_CYCLES = 8):
// a byte-level driver, an iomem responder with programmable wait states, a tx
// sink with selectable backpressure, and a frame-level reference model.
module tb_iomem_uart_master;

    localparam int TO = 8;

    logic clk;
    logic resetn;
    logic busy;

    iomem_uart_master_if bus ();

    iomem_uart_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          vlen;
        bit          acked;
        bit          is_write;
    } txn_t;

    int          n_checks;
    int          n_pass;
    int          rsp_wait;
    logic [31:0] rsp_rdata;
    int          tx_mode;
    txn_t        txn_q[$];
    logic [7:0]  tx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // iomem responder: ready after rsp_wait valid cycles (-1 = never), records each request
    initial begin
        txn_t cur;
        int   vcnt;
        bit   pulsed;
        vcnt = 0;
        pulsed = 0;
        cur = '{addr: 32'd0, wdata: 32'd0, wstrb: 4'd0, vlen: 0, acked: 1'b0, is_write: 1'b0};
        bus.iomem_ready = 1'b0;
        bus.iomem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.iomem_ready = 1'b0;
            bus.iomem_rdata = $urandom();
            if (!resetn) begin
                vcnt = 0;
                pulsed = 0;
            end else if (bus.iomem_valid) begin
                if (vcnt == 0) begin
                    cur.addr  = bus.iomem_addr;
                    cur.wdata = bus.iomem_wdata;
                    cur.wstrb = bus.iomem_wstrb;
                end else begin
                    check("addr_hold", bus.iomem_addr, cur.addr);
                    check("wdata_hold", bus.iomem_wdata, cur.wdata);
                    check("wstrb_hold", 32'(bus.iomem_wstrb), 32'(cur.wstrb));
                end
                if (!pulsed && rsp_wait >= 0 && vcnt == rsp_wait) begin
                    bus.iomem_ready = 1'b1;
                    bus.iomem_rdata = rsp_rdata;
                    pulsed = 1;
                end
                vcnt++;
            end else if (vcnt > 0) begin
                cur.vlen  = vcnt;
                cur.acked = pulsed;
                txn_q.push_back(cur);
                vcnt = 0;
                pulsed = 0;
            end
        end
    end

    // tx sink: mode 0 always ready, 1 toggles every 3 cycles, 2 random
    initial begin
        int         cyc;
        bit         hold;
        logic [7:0] hdata;
        cyc = 0;
        hold = 0;
        hdata = 8'd0;
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (tx_mode == 0)      bus.tx_ready = 1'b1;
            else if (tx_mode == 1) bus.tx_ready = ((cyc / 3) % 2) == 1;
            else                   bus.tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold && resetn) begin
                check("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
                check("tx_data_hold", 32'(bus.tx_data), 32'(hdata));
            end
            hold  = bus.tx_valid && !bus.tx_ready;
            hdata = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
        end
    end

    // Frame-level reference: response bytes and the single expected bus request
    function automatic void model(input logic [7:0] f[$], input int wt, input logic [31:0] rd,
                                  output logic [7:0] er[$], output bit has_txn, output txn_t et);
        int         p;
        logic [7:0] op;
        logic [7:0] sb;
        er = {};
        has_txn = 0;
        et = '{addr: 32'd0, wdata: 32'd0, wstrb: 4'd0, vlen: 0, acked: 1'b0, is_write: 1'b0};
        p = 0;
        while (p < f.size()) begin
            op = f[p];
            if (op == 8'h57 || op == 8'h52) begin
                et.addr = {f[p+1], f[p+2], f[p+3], f[p+4]};
                et.is_write = (op == 8'h57);
                if (et.is_write) begin
                    sb = f[p+5];
                    et.wstrb = sb[3:0];
                    et.wdata = {f[p+6], f[p+7], f[p+8], f[p+9]};
                    p += 10;
                end else begin
                    et.wstrb = 4'd0;
                    p += 5;
                end
                has_txn = 1;
                et.acked = (wt >= 0) && (wt < TO);
                et.vlen  = et.acked ? wt + 1 : TO;
                if (!et.acked) begin
                    er.push_back(8'h15);
                end else begin
                    er.push_back(8'h06);
                    if (!et.is_write) begin
                        er.push_back(rd[31:24]);
                        er.push_back(rd[23:16]);
                        er.push_back(rd[15:8]);
                        er.push_back(rd[7:0]);
                    end
                end
            end else begin
                er.push_back(8'h3F);
                p++;
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, output bit ok);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int wt, input logic [31:0] rd, input int mode);
        logic [7:0] er[$];
        bit         ht;
        txn_t       et;
        bit         ok;
        rsp_wait  = wt;
        rsp_rdata = rd;
        tx_mode   = mode;
        model(f, wt, rd, er, ht, et);
        txn_q.delete();
        tx_q.delete();
        foreach (f[i]) begin
            send_byte(f[i], ok);
            check("rx_accept", 32'(ok), 32'd1);
        end
        if (ht) check("valid_rise", 32'(bus.iomem_valid), 32'd1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            check("rx_ready_low", 32'(bus.rx_ready), 32'd0);
            if (tx_q.size() >= er.size()) break;
        end
        @(posedge clk);
        #1;
        check("resp_len", 32'(tx_q.size()), 32'(er.size()));
        foreach (er[i]) begin
            if (i < tx_q.size()) check($sformatf("resp_byte%0d", i), 32'(tx_q[i]), 32'(er[i]));
        end
        check("busy_idle", 32'(busy), 32'd0);
        check("rx_ready_idle", 32'(bus.rx_ready), 32'd1);
        check("txn_cnt", 32'(txn_q.size()), ht ? 32'd1 : 32'd0);
        if (ht && txn_q.size() > 0) begin
            check("txn_addr", txn_q[0].addr, et.addr);
            check("txn_wstrb", 32'(txn_q[0].wstrb), 32'(et.wstrb));
            check("txn_vlen", 32'(txn_q[0].vlen), 32'(et.vlen));
            check("txn_acked", 32'(txn_q[0].acked), 32'(et.acked));
            if (et.is_write) check("txn_wdata", txn_q[0].wdata, et.wdata);
        end
    endtask

    function automatic logic [7:0] rand_unknown();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom_range(0, 255));
        return b;
    endfunction

    initial begin
        logic [7:0]  f[$];
        logic [31:0] a;
        logic [31:0] d;
        bit          ok;
        int          kind;
        int          wt;
        n_checks = 0;
        n_pass = 0;
        rsp_wait = 0;
        rsp_rdata = 32'd0;
        tx_mode = 0;
        resetn = 1'b0;
        bus.rx_data = 8'd0;
        bus.rx_valid = 1'b0;

        #2;
        check("rst_valid", 32'(bus.iomem_valid), 32'd0);
        check("rst_addr", bus.iomem_addr, 32'd0);
        check("rst_wdata", bus.iomem_wdata, 32'd0);
        check("rst_wstrb", 32'(bus.iomem_wstrb), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        #20;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

        // Write with a one-wait responder
        f = '{8'h57, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07};
        run_frame(f, 1, 32'h0, 0);
        // Read returning DEADBEEF
        f = '{8'h52, 8'h06, 8'h00, 8'h00, 8'h00};
        run_frame(f, 0, 32'hDEADBEEF, 0);
        // Timeout, then ready exactly on the limit cycle, then one past it
        f = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        run_frame(f, -1, 32'h12345678, 0);
        run_frame(f, TO - 1, 32'hCAFEF00D, 0);
        run_frame(f, TO, 32'h0BADC0DE, 0);
        // Unknown opcode immediately followed by a write
        f = '{8'hAA, 8'h57, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFC, 8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(f, 0, 32'h0, 0);
        // Zero strobe write behaves as a discarded read
        f = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'hF0, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        run_frame(f, 2, 32'h55AA55AA, 0);
        // Read under periodic backpressure
        f = '{8'h52, 8'h02, 8'h00, 8'h00, 8'h10};
        run_frame(f, 3, 32'hA1B2C3D4, 1);

        // Asynchronous reset while a request is outstanding
        rsp_wait = -1;
        tx_mode = 0;
        f = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        foreach (f[i]) send_byte(f[i], ok);
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(bus.iomem_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.iomem_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        f = '{8'h52, 8'h05, 8'h00, 8'h00, 8'h00};
        run_frame(f, 0, 32'h01020304, 0);

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            f = {};
            if ($urandom_range(0, 3) == 0) f.push_back(rand_unknown());
            kind = $urandom_range(0, 2);
            a = $urandom();
            d = $urandom();
            if (kind == 0) begin
                f.push_back(8'h57);
                f.push_back(a[31:24]); f.push_back(a[23:16]); f.push_back(a[15:8]); f.push_back(a[7:0]);
                f.push_back(8'($urandom_range(0, 255)));
                f.push_back(d[31:24]); f.push_back(d[23:16]); f.push_back(d[15:8]); f.push_back(d[7:0]);
            end else if (kind == 1) begin
                f.push_back(8'h52);
                f.push_back(a[31:24]); f.push_back(a[23:16]); f.push_back(a[15:8]); f.push_back(a[7:0]);
            end else begin
                f.push_back(rand_unknown());
            end
            case ($urandom_range(0, 5))
                0:       wt = -1;
                1:       wt = TO - 1 + int'($urandom_range(0, 1));
                default: wt = int'($urandom_range(0, 3));
            endcase
            run_frame(f, wt, $urandom(), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
